seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL provide parameter N, default 4, pattern length in bits (legal range 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b1011, target sequence; PATTERN[N-1] is the first bit expected, PATTERN[0] the last.
REQ-003 SHALL provide parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL provide parameter CW, default 8, width of match_count.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  synchronous clear of detector state and count.
REQ-008 x_valid  input  1  qualifies x_in; a bit is accepted only on a rising edge with x_valid=1.
REQ-009 x_in  input  1  serial data bit.
REQ-010 y_out  output  1  Mealy detect: combinational, high in the cycle the completing bit is presented.
REQ-011 y_reg  output  1  registered detect: high for exactly one cycle following each accepted completing bit.
REQ-012 match_count  output  CW  saturating count of detections.
REQ-013 state_len  output  $clog2(N+1)  current matched-prefix length (0..N-1), for debug/verification.

Function
REQ-014 Matched length L SHALL equal the largest k < N such that the last k accepted bits equal PATTERN[N-1 -: k] (first k pattern bits), subject to REQ-017.
REQ-015 On an accepted bit: if L = N-1 and x_in = PATTERN[0] the bit SHALL complete a match; otherwise L SHALL update to the recomputed value per REQ-014 (KMP-style fallback, not reset-to-zero on mismatch).
REQ-016 On a match with OVERLAP=1, L SHALL become the longest proper suffix of PATTERN that is also a prefix (for 1011: L=1).
REQ-017 On a match with OVERLAP=0, L SHALL become 0 and bits up to and including the completing bit SHALL NOT contribute to any later match.
REQ-018 y_out SHALL equal x_valid & ~clr & (L = N-1) & (x_in = PATTERN[0]); no dependency on other inputs.
REQ-019 y_reg SHALL be the registered value of y_out (latency one cycle).
REQ-020 match_count SHALL increment by 1 per match, SHALL saturate at 2^CW-1, and SHALL never wrap.
REQ-021 x_valid=0 SHALL hold L, match_count unchanged; y_reg SHALL be 0 on the following cycle.
REQ-022 clr=1 SHALL, on the next rising edge, set L=0, match_count=0, y_reg=0; clr takes priority over a simultaneous accepted bit, which is discarded and not counted.
REQ-023 The fallback table for REQ-015/016 SHALL be derived from PATTERN at elaboration; no runtime pattern loading.

Reset
REQ-024 While reset=1, asynchronously: L=0, match_count=0, y_reg=0; y_out=0 follows from L=0 (N>=2).
REQ-025 Reset asserted mid-sequence SHALL discard all partial-match history; first accepted bit after release is treated as bit 1 of a fresh stream.
REQ-026 Reset SHALL take priority over clr and x_valid.

Verification (defaults N=4, PATTERN=1011, CW=8, x_valid=1 unless stated)
REQ-027 Stream 1,0,1,1 -> y_out=1 during bit 4 only, y_reg=1 the following cycle only, match_count=1, state_len sequence 1,2,3,1.
REQ-028 Stream 1,0,1,1,0,1,1 with OVERLAP=1 -> matches on bits 4 and 7, match_count=2; same stream with OVERLAP=0 -> match on bit 4 only, match_count=1.
REQ-029 Stream 1,1,0,1,1 -> state_len 1,1,2,3, match on bit 5 (fallback on repeated 1 keeps L=1).
REQ-030 Stream 1,0,(x_valid=0 for 3 cycles, x_in toggling),1,1 -> state_len holds 2 during gap, single match on final bit, y_out=0 throughout gap.
REQ-031 Stream 1,0,1, then reset pulse, then 1 -> no match, match_count=0, state_len=1; separately clr asserted with completing bit -> no match, match_count=0.
REQ-032 300 back-to-back 1011 patterns (OVERLAP=0) -> match_count reaches 255 and stays 255; y_out/y_reg still pulse for every match.

Source files
------------

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial bit stream in (clr, x_valid, x_in), detect/count/debug out (y_out, y_reg, match_count, state_len)
interface seq_detector_if #(
  parameter int N = 4,
  parameter int CW = 8
);
  logic clr;
  logic x_valid;
  logic x_in;
  logic y_out;
  logic y_reg;
  logic [CW-1:0] match_count;
  logic [$clog2(N+1)-1:0] state_len;
  modport master (output clr, x_valid, x_in, input y_out, y_reg, match_count, state_len);
  modport slave (input clr, x_valid, x_in, output y_out, y_reg, match_count, state_len);
endinterface

// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with KMP fallback; ports clock, reset (async high), bus (seq_detector_if.slave)
module seq_detector #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CW = 8
) (
  input logic clock,
  input logic reset,
  seq_detector_if.slave bus
);
  localparam int LW = $clog2(N + 1);
  typedef logic [2*(2**LW)-1:0][LW-1:0] tbl_t;
  function automatic bit pb(int i);
    logic [N-1:0] t;
    t = PATTERN >> i;
    return t[0];
  endfunction
  function automatic int fall(int l, bit b);
    int kmax;
    bit ok;
    bit s;
    if (l >= N) return 0;
    kmax = (l + 1 < N) ? l + 1 : N - 1;
    for (int k = kmax; k > 0; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        s = (l + 1 - k + i < l) ? pb(N - 1 - (l + 1 - k + i)) : b;
        if (s != pb(N - 1 - i)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction
  function automatic tbl_t build();
    tbl_t t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      t[2*i]   = LW'(fall(i, 1'b0));
      t[2*i+1] = LW'(fall(i, 1'b1));
    end
    return t;
  endfunction
  localparam tbl_t NEXT = build();
  logic [LW-1:0] l;
  logic [LW-1:0] nxt;
  assign bus.y_out = bus.x_valid & ~bus.clr & (l == LW'(N - 1)) & (bus.x_in == PATTERN[0]);
  assign nxt = (bus.y_out && !OVERLAP) ? '0 : NEXT[{l, bus.x_in}];
  assign bus.state_len = l;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l <= '0;
      bus.match_count <= '0;
      bus.y_reg <= 1'b0;
    end else if (bus.clr) begin
      l <= '0;
      bus.match_count <= '0;
      bus.y_reg <= 1'b0;
    end else begin
      bus.y_reg <= bus.y_out;
      if (bus.x_valid) l <= nxt;
      if (bus.y_out && bus.match_count != '1) bus.match_count <= bus.match_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: checks overlapping and non-overlapping detectors against a history-based model
module tb_seq_detector;
  localparam int N = 4;
  localparam int CW = 8;
  localparam logic [N-1:0] P = 4'b1011;
  typedef bit bq_t[$];
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  logic x_valid = 1'b0;
  logic x_in = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  seq_detector_if #(.N(N), .CW(CW)) io ();
  seq_detector_if #(.N(N), .CW(CW)) ino ();
  assign io.clr = clr;
  assign io.x_valid = x_valid;
  assign io.x_in = x_in;
  assign ino.clr = clr;
  assign ino.x_valid = x_valid;
  assign ino.x_in = x_in;
  seq_detector #(.N(N), .PATTERN(P), .OVERLAP(1'b1), .CW(CW)) u_ov (.clock(clock), .reset(reset), .bus(io.slave));
  seq_detector #(.N(N), .PATTERN(P), .OVERLAP(1'b0), .CW(CW)) u_no (.clock(clock), .reset(reset), .bus(ino.slave));
  always #5 clock = ~clock;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  function automatic bit is_match(bq_t h, bit x);
    bq_t s;
    s = h;
    s.push_back(x);
    if (s.size() < N) return 1'b0;
    for (int i = 0; i < N; i++) if (s[s.size() - N + i] != P[N-1-i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int plen(bq_t h);
    bit ok;
    for (int k = N - 1; k > 0; k--) begin
      if (h.size() >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) if (h[h.size() - k + i] != P[N-1-i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction
  function automatic bq_t nxt_hist(bq_t h, bit x, bit m, bit ov);
    bq_t s;
    s = h;
    s.push_back(x);
    if (m && !ov) s = {};
    while (s.size() > N) void'(s.pop_front());
    return s;
  endfunction
  function automatic bit ey(bq_t h);
    return x_valid && !clr && !reset && is_match(h, x_in);
  endfunction
  bq_t h1, h0;
  int c1, c0;
  bit r1, r0, m1, m0;
  always @(posedge clock or posedge reset) begin
    if (reset || clr) begin
      h1 = {}; h0 = {}; c1 = 0; c0 = 0; r1 = 0; r0 = 0;
    end else begin
      m1 = x_valid && is_match(h1, x_in);
      m0 = x_valid && is_match(h0, x_in);
      r1 = m1;
      r0 = m0;
      if (x_valid) begin
        h1 = nxt_hist(h1, x_in, m1, 1'b1);
        h0 = nxt_hist(h0, x_in, m0, 1'b0);
      end
      if (m1 && c1 < 2**CW - 1) c1++;
      if (m0 && c0 < 2**CW - 1) c0++;
    end
  end
  always @(negedge clock) begin
    chk("ov.y_out", int'(io.y_out), int'(ey(h1)));
    chk("ov.y_reg", int'(io.y_reg), int'(r1));
    chk("ov.count", int'(io.match_count), c1);
    chk("ov.state_len", int'(io.state_len), plen(h1));
    chk("no.y_out", int'(ino.y_out), int'(ey(h0)));
    chk("no.y_reg", int'(ino.y_reg), int'(r0));
    chk("no.count", int'(ino.match_count), c0);
    chk("no.state_len", int'(ino.state_len), plen(h0));
  end
  task automatic send(bit v, bit x, bit c, int e);
    x_valid = v;
    x_in = x;
    clr = c;
    #1;
    if (e >= 0) chk("lit.y_out", int'(io.y_out), e);
    @(posedge clock);
    #1;
  endtask
  initial begin
    #1;
    chk("lit.rst_count", int'(io.match_count), 0);
    chk("lit.rst_len", int'(io.state_len), 0);
    chk("lit.rst_yreg", int'(ino.y_reg), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    send(1, 1, 0, 0); chk("lit.len1", int'(io.state_len), 1);
    send(1, 0, 0, 0); chk("lit.len2", int'(io.state_len), 2);
    send(1, 1, 0, 0); chk("lit.len3", int'(io.state_len), 3);
    send(1, 1, 0, 1);
    chk("lit.len_after", int'(io.state_len), 1);
    chk("lit.yreg_pulse", int'(io.y_reg), 1);
    chk("lit.count1", int'(io.match_count), 1);
    send(0, 0, 0, 0); chk("lit.yreg_drop", int'(io.y_reg), 0);
    send(0, 0, 1, -1);
    send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 1, 0, 1);
    send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 1, 0, 1);
    chk("lit.ov_count2", int'(io.match_count), 2);
    chk("lit.no_count1", int'(ino.match_count), 1);
    send(0, 0, 1, -1);
    send(1, 1, 0, 0); send(1, 1, 0, 0); chk("lit.fallback_len", int'(io.state_len), 1);
    send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 1, 0, 1);
    chk("lit.11011_count", int'(io.match_count), 1);
    send(0, 0, 1, -1);
    send(1, 1, 0, 0); send(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      send(0, i[0], 0, 0);
      chk("lit.gap_len", int'(io.state_len), 2);
    end
    send(1, 1, 0, 0); send(1, 1, 0, 1);
    chk("lit.gap_count", int'(io.match_count), 1);
    send(0, 0, 1, -1);
    send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
    #2 reset = 1'b1;
    #1 chk("lit.async_len", int'(io.state_len), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    send(1, 1, 0, 0);
    chk("lit.rst_fresh_len", int'(io.state_len), 1);
    chk("lit.rst_fresh_count", int'(io.match_count), 0);
    send(1, 0, 0, 0); send(1, 1, 0, 0); send(1, 1, 1, 0);
    chk("lit.clr_count", int'(io.match_count), 0);
    chk("lit.clr_yreg", int'(io.y_reg), 0);
    chk("lit.clr_len", int'(io.state_len), 0);
    for (int i = 0; i < 300; i++) begin
      send(1, 1, 0, -1); send(1, 0, 0, -1); send(1, 1, 0, -1); send(1, 1, 0, 1);
    end
    chk("lit.sat_ov", int'(io.match_count), 255);
    chk("lit.sat_no", int'(ino.match_count), 255);
    chk("lit.sat_yreg", int'(ino.y_reg), 1);
    send(0, 0, 0, 0);
    chk("lit.sat_hold", int'(ino.match_count), 255);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
